debug_uart_cmd_responder: RTL and testbench
===========================================

Name: debug_uart_cmd_responder

Overview:
- Responder end of the debug UART link.
- Consumes bytes from the debug UART core's RX side (rx_dv/rx_byte), parses 6-byte request frames, and executes one register read or write on a simple handshake bus.
- Returns a 6-byte response frame through the core's TX handshake (tx_dv/tx_byte/tx_done).
- Sits between debug_uart_core and the hub's debug register file.

Parameters:
- ACK_TIMEOUT, 255: clk cycles to wait for reg_ack before aborting with status 0x03.
- RX_TIMEOUT, 40000: inter-byte timeout in clk cycles (1 ms at 40 MHz). Used only with DBG_RX_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_rx_dv  in  1  one-cycle strobe: in_rx_byte valid.
- in_rx_byte  in  8  received byte.
- out_tx_dv  out  1  one-cycle strobe: start transmitting out_tx_byte.
- out_tx_byte  out  8  byte to transmit; held stable until in_tx_done.
- in_tx_active  in  1  UART TX busy.
- in_tx_done  in  1  one-cycle strobe: byte fully sent.
- reg_addr  out  8  bus address.
- reg_wdata  out  16  bus write data.
- reg_wr  out  1  write request; held until reg_ack or timeout.
- reg_rd  out  1  read request; held until reg_ack or timeout.
- reg_rdata  in  16  read data; valid when reg_ack=1.
- reg_ack  in  1  one-cycle bus acknowledge.
- busy  out  1  high from accepted SYNC byte to last response byte done.

Behaviour:
- Reset (rst=0): all outputs 0, FSM in IDLE, counters and checksum cleared. Asynchronous. Takes effect mid-frame or mid-response; the UART core is not told to abort.
- Request frame: 0xA5, CMD, ADDR, DH, DL, CHK. CHK = XOR of CMD..DL.
  - CMD 0x01 = read. DH/DL are ignored but still covered by CHK.
  - CMD 0x02 = write.
- Response frame: 0x5A, STATUS, ADDR, DH, DL, CHK. CHK = XOR of STATUS..DL.
- STATUS codes:
  - 0x00 ok.
  - 0x01 bad checksum.
  - 0x02 bad command.
  - 0x03 bus timeout.
- Response DH/DL by case:
  - Read ok: reg_rdata.
  - Write ok: echo of the written data.
  - Any error: 0x0000.
- FSM states: IDLE, RX_CMD, RX_ADDR, RX_DH, RX_DL, RX_CHK, EXEC, WAIT_ACK, TX_LOAD, TX_WAIT.
- IDLE: on in_rx_dv with byte 0xA5 go to RX_CMD; any other byte is ignored.
- RX_*: each in_rx_dv latches the byte, updates the running XOR, and advances one state. A 0xA5 inside a frame is data, not a resync.
- RX_CHK → EXEC, evaluated in priority order:
  - Checksum mismatch → STATUS 0x01, no bus access.
  - Otherwise CMD not in {01,02} → STATUS 0x02, no bus access.
  - Otherwise assert reg_rd/reg_wr with reg_addr/reg_wdata the cycle after EXEC entry.
- WAIT_ACK:
  - reg_ack → latch reg_rdata on a read, deassert the request, STATUS 0x00.
  - ACK_TIMEOUT cycles without ack → deassert, STATUS 0x03.
  - reg_ack arriving in the same cycle the counter expires counts as success.
- TX_LOAD: drive out_tx_byte and pulse out_tx_dv for one cycle, only if in_tx_active=0; otherwise stall.
- TX_WAIT: on in_tx_done, increment the byte index 0..5. After index 5 go to IDLE and drop busy.
- Any in_rx_dv received during EXEC/WAIT_ACK/TX_* is dropped (no queuing).
- Latency: request bus strobe 1 cycle after the CHK byte strobe. First out_tx_dv ≤2 cycles after the bus completes.

Optional Feature:
- Macro DBG_RX_TIMEOUT_EN.
- Defined:
  - In RX_CMD..RX_CHK a counter reloads on each in_rx_dv.
  - If RX_TIMEOUT cycles elapse with no byte, the FSM returns to IDLE silently. No response, no bus access, busy drops.
- Undefined:
  - No counter is synthesised.
  - A partial frame waits indefinitely for its remaining bytes.

Decomposition:
- Shared package debug_uart_pkg holds:
  - SYNC_REQ=8'hA5, SYNC_RSP=8'h5A.
  - CMD_RD=8'h01, CMD_WR=8'h02.
  - STATUS_* codes.
  - The FSM state enum typedef.
- Sub-module debug_uart_resp_ser: 6-byte response serializer (TX_LOAD/TX_WAIT handshake, byte index, CHK generation). Started by a one-cycle start strobe, signals done.

Test Plan:
- Write: rx A5 02 10 12 34 34.
  - One reg_wr pulse-until-ack with addr 0x10, wdata 0x1234.
  - Response 5A 00 10 12 34 36.
- Read with reg_rdata=0xBEEF: rx A5 01 20 00 00 21.
  - reg_rd with addr 0x20.
  - Response 5A 00 20 BE EF 71.
- Bad checksum: rx A5 01 20 00 00 FF.
  - No reg_rd/reg_wr.
  - Response 5A 01 20 00 00 21.
- Bad command: rx A5 07 20 00 00 27.
  - Response 5A 02 20 00 00 22.
- Read 0x20 with reg_ack never asserted.
  - reg_rd drops after 255 cycles.
  - Response 5A 03 20 00 00 23.
- Leading junk and reset:
  - Junk bytes 00 FF before a valid frame are ignored and the frame is answered normally.
  - rst pulled low after the ADDR byte clears all outputs; the next full frame is handled correctly.
  - With DBG_RX_TIMEOUT_EN, a 40000-cycle gap after ADDR returns the FSM to IDLE with no response.

Source files
------------

// File: rtl/debug_uart_pkg.sv
// Shared constants and FSM state type for the debug UART command responder.
package debug_uart_pkg;

  localparam logic [7:0] SYNC_REQ = 8'hA5;
  localparam logic [7:0] SYNC_RSP = 8'h5A;

  localparam logic [7:0] CMD_RD = 8'h01;
  localparam logic [7:0] CMD_WR = 8'h02;

  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_BAD_CHK = 8'h01;
  localparam logic [7:0] STATUS_BAD_CMD = 8'h02;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h03;

  typedef enum logic [3:0] {
    StIdle,
    StRxCmd,
    StRxAddr,
    StRxDh,
    StRxDl,
    StRxChk,
    StExec,
    StWaitAck,
    StTxLoad,
    StTxWait
  } dbg_state_e;

endpackage

// File: rtl/debug_uart_resp_ser.sv
// Six-byte response serializer: 5A, STATUS, ADDR, DH, DL, CHK over the UART TX handshake.
module debug_uart_resp_ser
  import debug_uart_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [7:0]  status_i,
  input  logic [7:0]  addr_i,
  input  logic [15:0] data_i,
  input  logic        tx_active_i,
  input  logic        tx_done_i,
  output logic        tx_dv_o,
  output logic [7:0]  tx_byte_o,
  output logic        done_o
);

  logic       active_q, active_d;
  logic       load_q, load_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] chk;

  assign chk = status_i ^ addr_i ^ data_i[15:8] ^ data_i[7:0];

  always_comb begin
    active_d = active_q;
    load_d   = load_q;
    idx_d    = idx_q;
    tx_dv_o  = 1'b0;
    done_o   = 1'b0;
    if (start_i) begin
      active_d = 1'b1;
      load_d   = 1'b1;
      idx_d    = 3'd0;
    end else if (active_q && load_q) begin
      // Stall the load while the UART is still shifting a previous byte.
      if (!tx_active_i) begin
        tx_dv_o = 1'b1;
        load_d  = 1'b0;
      end
    end else if (active_q && tx_done_i) begin
      if (idx_q == 3'd5) begin
        active_d = 1'b0;
        done_o   = 1'b1;
      end else begin
        idx_d  = idx_q + 3'd1;
        load_d = 1'b1;
      end
    end
  end

  always_comb begin
    tx_byte_o = 8'h00;
    if (active_q) begin
      case (idx_q)
        3'd0:    tx_byte_o = SYNC_RSP;
        3'd1:    tx_byte_o = status_i;
        3'd2:    tx_byte_o = addr_i;
        3'd3:    tx_byte_o = data_i[15:8];
        3'd4:    tx_byte_o = data_i[7:0];
        default: tx_byte_o = chk;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      load_q   <= 1'b0;
      idx_q    <= 3'd0;
    end else begin
      active_q <= active_d;
      load_q   <= load_d;
      idx_q    <= idx_d;
    end
  end

endmodule

// File: rtl/debug_uart_cmd_responder.sv
// Debug UART responder: parses 6-byte request frames, runs one register access, replies.
// Optional inter-byte receive timeout enabled by defining DBG_RX_TIMEOUT_EN.
module debug_uart_cmd_responder
  import debug_uart_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned RX_TIMEOUT  = 40000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_rx_dv,
  input  logic [7:0]  in_rx_byte,
  output logic        out_tx_dv,
  output logic [7:0]  out_tx_byte,
  input  logic        in_tx_active,
  input  logic        in_tx_done,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  input  logic        reg_ack,
  output logic        busy
);

  localparam int unsigned AckW = $clog2(ACK_TIMEOUT + 1);

  dbg_state_e      state_q, state_d;
  logic [7:0]      cmd_q, cmd_d, addr_q, addr_d, dh_q, dh_d, dl_q, dl_d;
  logic [7:0]      xor_q, xor_d, status_q, status_d;
  logic [15:0]     rsp_data_q, rsp_data_d;
  logic            rd_q, rd_d, wr_q, wr_d;
  logic [AckW-1:0] ack_cnt_q, ack_cnt_d;
  logic            ser_start, ser_done;
  logic            chk_ok, cmd_ok, rx_expired;

`ifdef DBG_RX_TIMEOUT_EN
  localparam int unsigned RxW = $clog2(RX_TIMEOUT + 1);
  logic [RxW-1:0] rx_tmr_q, rx_tmr_d;
  logic           in_rx_state;

  assign in_rx_state = state_q inside {StRxCmd, StRxAddr, StRxDh, StRxDl, StRxChk};
  assign rx_expired  = in_rx_state && !in_rx_dv && (rx_tmr_q == RxW'(RX_TIMEOUT - 1));

  always_comb begin
    rx_tmr_d = '0;
    if (in_rx_state && !in_rx_dv) rx_tmr_d = rx_tmr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_tmr_q <= '0;
    else      rx_tmr_q <= rx_tmr_d;
  end
`else
  assign rx_expired = 1'b0;
`endif

  assign chk_ok = (xor_q == in_rx_byte);
  assign cmd_ok = (cmd_q == CMD_RD) || (cmd_q == CMD_WR);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    dh_d       = dh_q;
    dl_d       = dl_q;
    xor_d      = xor_q;
    status_d   = status_q;
    rsp_data_d = rsp_data_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    ack_cnt_d  = ack_cnt_q;
    ser_start  = 1'b0;
    unique case (state_q)
      StIdle: if (in_rx_dv && in_rx_byte == SYNC_REQ) begin
        xor_d   = 8'h00;
        state_d = StRxCmd;
      end
      StRxCmd: if (in_rx_dv) begin
        cmd_d   = in_rx_byte;
        xor_d   = xor_q ^ in_rx_byte;
        state_d = StRxAddr;
      end
      StRxAddr: if (in_rx_dv) begin
        addr_d  = in_rx_byte;
        xor_d   = xor_q ^ in_rx_byte;
        state_d = StRxDh;
      end
      StRxDh: if (in_rx_dv) begin
        dh_d    = in_rx_byte;
        xor_d   = xor_q ^ in_rx_byte;
        state_d = StRxDl;
      end
      StRxDl: if (in_rx_dv) begin
        dl_d    = in_rx_byte;
        xor_d   = xor_q ^ in_rx_byte;
        state_d = StRxChk;
      end
      // Decide on the CHK strobe itself so the bus request appears one cycle later.
      StRxChk: if (in_rx_dv) begin
        state_d    = StExec;
        ack_cnt_d  = '0;
        rsp_data_d = 16'h0000;
        if (!chk_ok) begin
          status_d = STATUS_BAD_CHK;
        end else if (!cmd_ok) begin
          status_d = STATUS_BAD_CMD;
        end else begin
          status_d = STATUS_OK;
          rd_d     = (cmd_q == CMD_RD);
          wr_d     = (cmd_q == CMD_WR);
          if (cmd_q == CMD_WR) rsp_data_d = {dh_q, dl_q};
        end
      end
      StExec, StWaitAck: begin
        if (!(rd_q || wr_q)) begin
          state_d = StTxLoad;
        end else if (reg_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (rd_q) rsp_data_d = reg_rdata;
          state_d = StTxLoad;
        end else if (ack_cnt_q == AckW'(ACK_TIMEOUT - 1)) begin
          rd_d       = 1'b0;
          wr_d       = 1'b0;
          status_d   = STATUS_TIMEOUT;
          rsp_data_d = 16'h0000;
          state_d    = StTxLoad;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
          state_d   = StWaitAck;
        end
      end
      StTxLoad: begin
        ser_start = 1'b1;
        state_d   = StTxWait;
      end
      StTxWait: if (ser_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (rx_expired) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cmd_q      <= 8'h00;
      addr_q     <= 8'h00;
      dh_q       <= 8'h00;
      dl_q       <= 8'h00;
      xor_q      <= 8'h00;
      status_q   <= 8'h00;
      rsp_data_q <= 16'h0000;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      ack_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      dh_q       <= dh_d;
      dl_q       <= dl_d;
      xor_q      <= xor_d;
      status_q   <= status_d;
      rsp_data_q <= rsp_data_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      ack_cnt_q  <= ack_cnt_d;
    end
  end

  assign reg_addr  = addr_q;
  assign reg_wdata = {dh_q, dl_q};
  assign reg_rd    = rd_q;
  assign reg_wr    = wr_q;
  assign busy      = (state_q != StIdle);

  debug_uart_resp_ser u_ser (
    .clk_i       (clk),
    .rst_ni      (rst),
    .start_i     (ser_start),
    .status_i    (status_q),
    .addr_i      (addr_q),
    .data_i      (rsp_data_q),
    .tx_active_i (in_tx_active),
    .tx_done_i   (in_tx_done),
    .tx_dv_o     (out_tx_dv),
    .tx_byte_o   (out_tx_byte),
    .done_o      (ser_done)
  );

endmodule

// File: tb/tb_debug_uart_cmd_responder.sv
// Directed bench for debug_uart_cmd_responder with UART TX and register-bus models.
module tb_debug_uart_cmd_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_rx_dv = 1'b0;
  logic [7:0]  in_rx_byte = 8'h00;
  logic        out_tx_dv;
  logic [7:0]  out_tx_byte;
  logic        in_tx_active = 1'b0;
  logic        in_tx_done = 1'b0;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr, reg_rd;
  logic [15:0] reg_rdata = 16'h0000;
  logic        reg_ack = 1'b0;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] rsp_buf [0:255];
  int rsp_n = 0;
  int rd_ptr = 0;

  bit ack_en = 1'b1;
  int ack_delay = 2;
  int ack_wait = 0;
  int rd_starts = 0, wr_starts = 0, rd_hi = 0;
  logic rd_prev = 1'b0, wr_prev = 1'b0;

  int s_rd, s_wr, s_hi, s_n;

  always #5 clk = ~clk;

  debug_uart_cmd_responder dut (
    .clk          (clk),
    .rst          (rst),
    .in_rx_dv     (in_rx_dv),
    .in_rx_byte   (in_rx_byte),
    .out_tx_dv    (out_tx_dv),
    .out_tx_byte  (out_tx_byte),
    .in_tx_active (in_tx_active),
    .in_tx_done   (in_tx_done),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_wr       (reg_wr),
    .reg_rd       (reg_rd),
    .reg_rdata    (reg_rdata),
    .reg_ack      (reg_ack),
    .busy         (busy)
  );

  // UART TX model: takes the byte, goes active after the sampling edge, signals done later.
  always begin
    @(negedge clk);
    while (out_tx_dv) begin
      if (rsp_n < 256) rsp_buf[rsp_n] = out_tx_byte;
      rsp_n++;
      @(posedge clk);
      #1 in_tx_active = 1'b1;
      repeat (3) @(negedge clk);
      in_tx_done   = 1'b1;
      in_tx_active = 1'b0;
      @(negedge clk);
      in_tx_done = 1'b0;
    end
  end

  // Register-bus slave model with programmable ack delay and request bookkeeping.
  always @(negedge clk) begin
    reg_ack = 1'b0;
    if (reg_rd && !rd_prev) rd_starts++;
    if (reg_wr && !wr_prev) wr_starts++;
    if (reg_rd) rd_hi++;
    rd_prev = reg_rd;
    wr_prev = reg_wr;
    if ((reg_rd || reg_wr) && ack_en) begin
      if (ack_wait == ack_delay) begin
        reg_ack  = 1'b1;
        ack_wait = 0;
      end else begin
        ack_wait++;
      end
    end else begin
      ack_wait = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    in_rx_dv   = 1'b1;
    in_rx_byte = b;
    @(negedge clk);
    in_rx_dv = 1'b0;
  endtask

  // Leaves the caller on the negedge right after the CHK strobe was sampled.
  task automatic send_frame(input logic [47:0] f);
    for (int i = 0; i < 6; i++) begin
      send_byte(f[47-8*i -: 8]);
      if (i < 5) repeat (2) @(negedge clk);
    end
  endtask

  task automatic expect_rsp(input string tag, input logic [47:0] exp);
    int need;
    int t;
    need = rd_ptr + 6;
    t = 0;
    while (rsp_n < need && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " complete"}, 32'(rsp_n >= need), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("%s byte%0d", tag, i), 32'(rsp_buf[rd_ptr+i]), 32'(exp[47-8*i -: 8]));
    end
    rd_ptr = need;
    repeat (8) @(negedge clk);
    chk({tag, " busy low"}, 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst out_tx_dv", 32'(out_tx_dv), 32'd0);
    chk("rst out_tx_byte", 32'(out_tx_byte), 32'd0);
    chk("rst reg_wr", 32'(reg_wr), 32'd0);
    chk("rst reg_rd", 32'(reg_rd), 32'd0);
    chk("rst reg_addr", 32'(reg_addr), 32'd0);
    chk("rst reg_wdata", 32'(reg_wdata), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Write 0x1234 to 0x10
    s_rd = rd_starts;
    s_wr = wr_starts;
    send_frame(48'hA5_02_10_12_34_34);
    chk("wr req", 32'(reg_wr), 32'd1);
    chk("wr addr", 32'(reg_addr), 32'h10);
    chk("wr wdata", 32'(reg_wdata), 32'h1234);
    chk("wr busy", 32'(busy), 32'd1);
    expect_rsp("wr rsp", 48'h5A_00_10_12_34_36);
    chk("wr count", 32'(wr_starts - s_wr), 32'd1);
    chk("wr no rd", 32'(rd_starts - s_rd), 32'd0);

    // Read 0x20 returning 0xBEEF
    reg_rdata = 16'hBEEF;
    s_rd = rd_starts;
    send_frame(48'hA5_01_20_00_00_21);
    chk("rd req", 32'(reg_rd), 32'd1);
    chk("rd no wr", 32'(reg_wr), 32'd0);
    chk("rd addr", 32'(reg_addr), 32'h20);
    expect_rsp("rd rsp", 48'h5A_00_20_BE_EF_71);
    chk("rd count", 32'(rd_starts - s_rd), 32'd1);

    // Bad checksum
    s_rd = rd_starts;
    s_wr = wr_starts;
    send_frame(48'hA5_01_20_00_00_FF);
    chk("badchk no rd", 32'(reg_rd), 32'd0);
    expect_rsp("badchk rsp", 48'h5A_01_20_00_00_21);
    chk("badchk bus idle", 32'((rd_starts - s_rd) + (wr_starts - s_wr)), 32'd0);

    // Bad command
    s_rd = rd_starts;
    s_wr = wr_starts;
    send_frame(48'hA5_07_20_00_00_27);
    expect_rsp("badcmd rsp", 48'h5A_02_20_00_00_22);
    chk("badcmd bus idle", 32'((rd_starts - s_rd) + (wr_starts - s_wr)), 32'd0);

    // Bus timeout: ack never comes
    ack_en = 1'b0;
    s_hi = rd_hi;
    s_rd = rd_starts;
    send_frame(48'hA5_01_20_00_00_21);
    expect_rsp("tmo rsp", 48'h5A_03_20_00_00_23);
    chk("tmo rd cycles", 32'(rd_hi - s_hi), 32'd255);
    chk("tmo rd count", 32'(rd_starts - s_rd), 32'd1);
    ack_en = 1'b1;

    // Leading junk, including 0xFF, before a valid write
    send_byte(8'h00);
    send_byte(8'hFF);
    chk("junk busy", 32'(busy), 32'd0);
    send_frame(48'hA5_02_33_AB_CD_57);
    chk("junk wdata", 32'(reg_wdata), 32'hABCD);
    chk("junk addr", 32'(reg_addr), 32'h33);
    expect_rsp("junk rsp", 48'h5A_00_33_AB_CD_55);

    // Reset after the ADDR byte
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h20);
    chk("mid busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst addr", 32'(reg_addr), 32'd0);
    chk("mid rst rd", 32'(reg_rd), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    s_n = rsp_n;
    send_frame(48'hA5_01_20_00_00_21);
    chk("post rst rd", 32'(reg_rd), 32'd1);
    expect_rsp("post rst rsp", 48'h5A_00_20_BE_EF_71);
    chk("post rst rsp count", 32'(rsp_n - s_n), 32'd6);

`ifdef DBG_RX_TIMEOUT_EN
    // Stalled partial frame is dropped silently
    s_n = rsp_n;
    s_rd = rd_starts;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h20);
    repeat (40010) @(negedge clk);
    chk("rxtmo busy", 32'(busy), 32'd0);
    chk("rxtmo no rsp", 32'(rsp_n - s_n), 32'd0);
    chk("rxtmo no rd", 32'(rd_starts - s_rd), 32'd0);
    send_frame(48'hA5_01_20_00_00_21);
    expect_rsp("rxtmo next rsp", 48'h5A_00_20_BE_EF_71);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
